// File: rtl/kart_pkg.sv
// Shared kart motion definitions: command codes, H-bridge pin encodings and
// the motor driver FSM state type.
package kart_pkg;

  localparam logic [2:0] STOP      = 3'b000;
  localparam logic [2:0] FORWARD   = 3'b001;
  localparam logic [2:0] LEFT      = 3'b010;
  localparam logic [2:0] RIGHT     = 3'b011;
  localparam logic [2:0] BACKWARD  = 3'b101;
  localparam logic [2:0] BACKLEFT  = 3'b110;
  localparam logic [2:0] BACKRIGHT = 3'b111;

  localparam logic [1:0] PIN_FWD   = 2'b10;
  localparam logic [1:0] PIN_BACK  = 2'b01;
  localparam logic [1:0] PIN_COAST = 2'b00;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DEAD
  } drv_state_e;

  function automatic logic [1:0] dir_pins(input logic dir);
    return dir ? PIN_BACK : PIN_FWD;
  endfunction

endpackage

// File: rtl/motor_cmd_driver_if.sv
// Tracker-to-motor bundle: motion command in, H-bridge pins/enables out.
interface motor_cmd_driver_if;
  import kart_pkg::*;

  logic [2:0] state;
  logic [1:0] left_motor;
  logic [1:0] right_motor;
  logic       left_pwm;
  logic       right_pwm;
  logic       reversing;

  modport master (
    output state,
    input  left_motor, right_motor, left_pwm, right_pwm, reversing
  );

  modport slave (
    input  state,
    output left_motor, right_motor, left_pwm, right_pwm, reversing
  );

endinterface

// File: rtl/motor_cmd_driver_duty_ramp.sv
// duty_ramp: one wheel's duty register, moved toward its target on each step pulse.
// SOFT_START_EN selects RAMP_STEP-limited steps; otherwise the duty jumps to target.
module duty_ramp
  import kart_pkg::*;
#(
  parameter int PWM_BITS  = 10,
  parameter int RAMP_STEP = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step_i,
  input  logic                force_zero_i,
  input  logic [PWM_BITS-1:0] target_i,
  output logic [PWM_BITS-1:0] duty_o,
  output logic [PWM_BITS-1:0] duty_d_o
);

  // A step wider than any possible duty gap makes every move a direct jump.
`ifdef SOFT_START_EN
  localparam int unsigned STEP = RAMP_STEP;
`else
  localparam int unsigned STEP = RAMP_STEP + (1 << PWM_BITS);
`endif

  logic [PWM_BITS-1:0] duty_q, duty_d, toward;

  always_comb begin
    toward = target_i;
    if (duty_q < target_i) begin
      if (32'(target_i) - 32'(duty_q) > STEP) toward = duty_q + PWM_BITS'(STEP);
    end else if (32'(duty_q) - 32'(target_i) > STEP) begin
      toward = duty_q - PWM_BITS'(STEP);
    end
  end

  always_comb begin
    duty_d = duty_q;
    if (step_i) duty_d = force_zero_i ? '0 : toward;
  end

  always_ff @(posedge clk) begin
    if (reset) duty_q <= '0;
    else       duty_q <= duty_d;
  end

  assign duty_o   = duty_q;
  assign duty_d_o = duty_d;

endmodule

// File: rtl/motor_cmd_driver.sv
// Kart motor driver: turns tracker commands into H-bridge pins and PWM enables with
// duty ramping and a drain + dead-time reversal sequence (ramping under SOFT_START_EN).
module motor_cmd_driver
  import kart_pkg::*;
#(
  parameter int PWM_BITS     = 10,
  parameter int FAST_DUTY    = 800,
  parameter int SLOW_DUTY    = 400,
  parameter int RAMP_STEP    = 8,
  parameter int DEAD_PERIODS = 4
) (
  input  logic               clk,
  input  logic               reset,
  motor_cmd_driver_if.slave  bus
);

  localparam logic [PWM_BITS-1:0] FAST = PWM_BITS'(FAST_DUTY);
  localparam logic [PWM_BITS-1:0] SLOW = PWM_BITS'(SLOW_DUTY);
  localparam int DCW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_PERIODS - 1);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  drv_state_e          fsm_q;
  logic                cur_dir_q;
  logic [DCW-1:0]      dead_cnt_q;
  logic [1:0]          pins_q;
  logic                lpwm_q, rpwm_q, rev_q;

  logic                bnd, is_stop, req_dir, both_zero, seek, force_zero;
  logic [PWM_BITS-1:0] tgt_l, tgt_r, ramp_tgt_l, ramp_tgt_r;
  logic [PWM_BITS-1:0] duty_l_q, duty_r_q, duty_l_d, duty_r_d;

  assign cnt_d     = cnt_q + PWM_BITS'(1);
  assign bnd       = &cnt_q;
  assign is_stop   = bus.state[1:0] == STOP[1:0];
  assign req_dir   = bus.state[2];
  assign both_zero = (duty_l_q == '0) && (duty_r_q == '0);

  always_comb begin
    tgt_l = '0;
    tgt_r = '0;
    case (bus.state[1:0])
      FORWARD[1:0]: begin tgt_l = FAST; tgt_r = FAST; end
      LEFT[1:0]:    begin tgt_l = SLOW; tgt_r = FAST; end
      RIGHT[1:0]:   begin tgt_l = FAST; tgt_r = SLOW; end
      default:      begin tgt_l = '0;   tgt_r = '0;   end
    endcase
  end

  // Only a same-direction run command seeks a nonzero duty; DRAIN and a
  // pending reversal seek zero, while STOP and DEAD clear the duty outright.
  assign seek       = (fsm_q == ST_RUN) && !is_stop && (req_dir == cur_dir_q);
  assign force_zero = (fsm_q == ST_DEAD) || ((fsm_q == ST_RUN) && is_stop);
  assign ramp_tgt_l = seek ? tgt_l : '0;
  assign ramp_tgt_r = seek ? tgt_r : '0;

  duty_ramp #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_ramp_l (
    .clk(clk), .reset(reset), .step_i(bnd), .force_zero_i(force_zero),
    .target_i(ramp_tgt_l), .duty_o(duty_l_q), .duty_d_o(duty_l_d)
  );

  duty_ramp #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_ramp_r (
    .clk(clk), .reset(reset), .step_i(bnd), .force_zero_i(force_zero),
    .target_i(ramp_tgt_r), .duty_o(duty_r_q), .duty_d_o(duty_r_d)
  );

  // PWM compares against next-cycle count and duty so new settings land exactly at cnt == 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      fsm_q      <= ST_RUN;
      cur_dir_q  <= 1'b0;
      dead_cnt_q <= '0;
      pins_q     <= PIN_COAST;
      lpwm_q     <= 1'b0;
      rpwm_q     <= 1'b0;
      rev_q      <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lpwm_q <= cnt_d < duty_l_d;
      rpwm_q <= cnt_d < duty_r_d;
      if (bnd) begin
        case (fsm_q)
          ST_RUN: begin
            if (is_stop) begin
              pins_q <= PIN_COAST;
            end else if (req_dir == cur_dir_q) begin
              pins_q <= dir_pins(cur_dir_q);
            end else if (both_zero) begin
              fsm_q      <= ST_DEAD;
              dead_cnt_q <= '0;
              pins_q     <= PIN_COAST;
              rev_q      <= 1'b1;
            end else begin
              fsm_q  <= ST_DRAIN;
              pins_q <= dir_pins(cur_dir_q);
              rev_q  <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (both_zero) begin
              fsm_q      <= ST_DEAD;
              dead_cnt_q <= '0;
              pins_q     <= PIN_COAST;
            end
          end
          ST_DEAD: begin
            if (dead_cnt_q == DEAD_LAST) begin
              fsm_q     <= ST_RUN;
              cur_dir_q <= ~cur_dir_q;
              pins_q    <= dir_pins(~cur_dir_q);
              rev_q     <= 1'b0;
            end else begin
              dead_cnt_q <= dead_cnt_q + DCW'(1);
            end
          end
          default: fsm_q <= ST_RUN;
        endcase
      end
    end
  end

  assign bus.left_motor  = pins_q;
  assign bus.right_motor = pins_q;
  assign bus.left_pwm    = lpwm_q;
  assign bus.right_pwm   = rpwm_q;
  assign bus.reversing   = rev_q;

endmodule

// File: tb/tb_motor_cmd_driver.sv
// Bench for motor_cmd_driver: directed and random commands, one PWM period at a time,
// compared every cycle against a period-level model (follows SOFT_START_EN).
module tb_motor_cmd_driver;
  import kart_pkg::*;

  localparam int PB = 4, FAST = 12, SLOW = 6, STEP = 4, DEADP = 2;
  localparam int PER = 1 << PB;
`ifdef SOFT_START_EN
  localparam int EFF_STEP = STEP;
`else
  localparam int EFF_STEP = PER;
`endif
  localparam int M_RUN = 0, M_DRAIN = 1, M_DEAD = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  motor_cmd_driver_if bus();

  motor_cmd_driver #(
    .PWM_BITS(PB), .FAST_DUTY(FAST), .SLOW_DUTY(SLOW),
    .RAMP_STEP(STEP), .DEAD_PERIODS(DEADP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int m_mode, m_dir, m_ld, m_rd, m_dead, m_pins, m_period;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int approach(input int cur, input int tgt);
    if (cur < tgt) return (cur + EFF_STEP >= tgt) ? tgt : cur + EFF_STEP;
    return (cur - EFF_STEP <= tgt) ? tgt : cur - EFF_STEP;
  endfunction

  function automatic int pins_of(input int dir);
    return dir ? int'(PIN_BACK) : int'(PIN_FWD);
  endfunction

  task automatic model_reset;
    m_mode = M_RUN; m_dir = 0; m_ld = 0; m_rd = 0; m_dead = 0; m_pins = int'(PIN_COAST);
  endtask

  // Applies the command seen at a period boundary to the model.
  task automatic boundary(input logic [2:0] cmd);
    int lo, tl, tr;
    lo = int'(cmd[1:0]);
    tl = (lo == 0) ? 0 : ((lo == 2) ? SLOW : FAST);
    tr = (lo == 0) ? 0 : ((lo == 3) ? SLOW : FAST);
    case (m_mode)
      M_RUN: begin
        if (lo == 0) begin
          m_ld = 0; m_rd = 0; m_pins = int'(PIN_COAST);
        end else if (int'(cmd[2]) == m_dir) begin
          m_ld = approach(m_ld, tl); m_rd = approach(m_rd, tr); m_pins = pins_of(m_dir);
        end else if (m_ld == 0 && m_rd == 0) begin
          m_mode = M_DEAD; m_dead = 0; m_pins = int'(PIN_COAST);
        end else begin
          m_mode = M_DRAIN; m_ld = approach(m_ld, 0); m_rd = approach(m_rd, 0);
          m_pins = pins_of(m_dir);
        end
      end
      M_DRAIN: begin
        if (m_ld == 0 && m_rd == 0) begin
          m_mode = M_DEAD; m_dead = 0; m_pins = int'(PIN_COAST);
        end else begin
          m_ld = approach(m_ld, 0); m_rd = approach(m_rd, 0);
        end
      end
      default: begin
        m_dead++;
        if (m_dead == DEADP) begin
          m_mode = M_RUN; m_dir = 1 - m_dir; m_pins = pins_of(m_dir);
        end
      end
    endcase
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One PWM period; optional mid-period command glitch or reset at cycle rst_at.
  task automatic period(input logic [2:0] cmd, input bit glitch, input int rst_at);
    for (int c = 0; c < PER; c++) begin
      if (c == 0) bus.state = cmd;
      if (glitch && c == 5) bus.state = cmd ^ 3'b101;
      if (glitch && c == 11) bus.state = cmd;
      if (c == rst_at) begin
        reset = 1'b1;
        tick();
        check($sformatf("p%0d rst_mid lm", m_period), 8'(bus.left_motor), 8'(0));
        check($sformatf("p%0d rst_mid rm", m_period), 8'(bus.right_motor), 8'(0));
        check($sformatf("p%0d rst_mid lpwm", m_period), 8'(bus.left_pwm), 8'(0));
        check($sformatf("p%0d rst_mid rpwm", m_period), 8'(bus.right_pwm), 8'(0));
        check($sformatf("p%0d rst_mid rev", m_period), 8'(bus.reversing), 8'(0));
        reset = 1'b0;
        model_reset();
        m_period++;
        return;
      end
      check($sformatf("p%0d c%0d lm", m_period, c), 8'(bus.left_motor), 8'(m_pins));
      check($sformatf("p%0d c%0d rm", m_period, c), 8'(bus.right_motor), 8'(m_pins));
      check($sformatf("p%0d c%0d lpwm", m_period, c), 8'(bus.left_pwm), 8'(c < m_ld));
      check($sformatf("p%0d c%0d rpwm", m_period, c), 8'(bus.right_pwm), 8'(c < m_rd));
      check($sformatf("p%0d c%0d rev", m_period, c), 8'(bus.reversing), 8'(m_mode != M_RUN));
      tick();
    end
    boundary(cmd);
    m_period++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] rc;
    int n;
    m_period = 0;
    bus.state = STOP;
    reset = 1'b1;
    tick();
    tick();
    check("reset lm", 8'(bus.left_motor), 8'(0));
    check("reset rm", 8'(bus.right_motor), 8'(0));
    check("reset lpwm", 8'(bus.left_pwm), 8'(0));
    check("reset rpwm", 8'(bus.right_pwm), 8'(0));
    check("reset rev", 8'(bus.reversing), 8'(0));
    reset = 1'b0;
    model_reset();

    repeat (5) period(FORWARD, 1'b0, -1);
    repeat (3) period(LEFT, 1'b0, -1);
    repeat (3) period(RIGHT, 1'b0, -1);
    repeat (2) period(FORWARD, 1'b0, -1);
    repeat (10) period(BACKWARD, 1'b0, -1);
    repeat (3) period(BACKLEFT, 1'b0, -1);
    repeat (2) period(BACKRIGHT, 1'b0, -1);
    repeat (3) period(FORWARD, 1'b0, -1);
    repeat (8) period(BACKWARD, 1'b0, -1);
    repeat (2) period(STOP, 1'b0, -1);
    repeat (4) period(BACKWARD, 1'b0, -1);
    repeat (2) period(3'b100, 1'b0, -1);
    repeat (2) period(BACKWARD, 1'b0, -1);
    repeat (3) period(BACKWARD, 1'b1, -1);

    for (int s = 0; s < 40; s++) begin
      rc = 3'($urandom_range(0, 7));
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) period(rc, 1'($urandom_range(0, 1)), -1);
    end

    period(FORWARD, 1'b0, 3);
    repeat (4) period(FORWARD, 1'b0, -1);
    period(BACKWARD, 1'b0, -1);
    period(BACKWARD, 1'b0, 7);
    repeat (4) period(FORWARD, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
